// File: rtl/jk_universal_ff_bank.sv
// jk_universal_ff_bank: WIDTH-bit mode-switchable JK/SR/D/T register bank with sticky SR-illegal mask and saturating change counter
module jk_universal_ff_bank #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_Q = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err_mask,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             cnt_sat
);
  logic [WIDTH-1:0] jk_nxt, sr_nxt, q_nxt, err_set;
  logic [CNT_W-1:0] cnt_nxt;
  assign qb = ~q;
  always_comb begin
    jk_nxt  = (a & ~q) | (~b & q);
    sr_nxt  = (a & ~b) | (q & ~(b & ~a));
    q_nxt   = !en ? q : mode == 2'b00 ? jk_nxt : mode == 2'b01 ? sr_nxt : mode == 2'b10 ? a : q ^ a;
    err_set = (en && mode == 2'b01) ? a & b : '0;
    cnt_nxt = clr_cnt ? '0 : (q_nxt != q && !(&chg_cnt)) ? chg_cnt + 1'b1 : chg_cnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q        <= RESET_Q;
      err_mask <= '0;
      chg_cnt  <= '0;
      cnt_sat  <= 1'b0;
    end else begin
      q        <= q_nxt;
      err_mask <= (clr_err ? '0 : err_mask) | err_set;
      chg_cnt  <= cnt_nxt;
      cnt_sat  <= &cnt_nxt;
    end
  end
endmodule

// File: tb/tb_jk_universal_ff_bank.sv
// tb_jk_universal_ff_bank: directed and random checks of jk_universal_ff_bank against a per-bit behavioural model
module tb_jk_universal_ff_bank;
  logic       clk = 1'b0, reset = 1'b0, en = 1'b0, clr_err = 1'b0, clr_cnt = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] a = '0, b = '0;
  logic [3:0] q, qb, err_mask;
  logic [2:0] chg_cnt;
  logic       cnt_sat;
  int errors = 0, checks = 0;
  int mq = 0, merr = 0, mcnt = 0;

  jk_universal_ff_bank #(.WIDTH(4), .CNT_W(3), .RESET_Q(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .clr_cnt(clr_cnt), .q(q), .qb(qb),
    .err_mask(err_mask), .chg_cnt(chg_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".q"}, {28'd0, q}, mq);
    chk({tag, ".qb"}, {28'd0, qb}, 15 - mq);
    chk({tag, ".err"}, {28'd0, err_mask}, merr);
    chk({tag, ".cnt"}, {29'd0, chg_cnt}, mcnt);
    chk({tag, ".sat"}, {31'd0, cnt_sat}, (mcnt == 7) ? 1 : 0);
  endtask

  // Model evaluates each bit from the truth tables using the pre-edge inputs
  task automatic model_edge();
    int nq, set_err;
    nq = mq;
    set_err = 0;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        int qi, ai, bi, ni;
        qi = (mq >> i) & 1;
        ai = int'(a[i]);
        bi = int'(b[i]);
        case (mode)
          2'd0: ni = (ai && bi) ? 1 - qi : ai ? 1 : bi ? 0 : qi;
          2'd1: begin
            ni = (ai && bi) ? qi : ai ? 1 : bi ? 0 : qi;
            if (ai && bi) set_err += (1 << i);
          end
          2'd2: ni = ai;
          default: ni = ai ? 1 - qi : qi;
        endcase
        nq = (nq & ~(1 << i)) | (ni << i);
      end
    end
    merr = (clr_err ? 0 : merr) | set_err;
    if (clr_cnt) mcnt = 0;
    else if (nq != mq && mcnt < 7) mcnt++;
    mq = nq;
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] m, input logic [3:0] ai, input logic [3:0] bi,
                      input logic ce, input logic cc);
    en = e; mode = m; a = ai; b = bi; clr_err = ce; clr_cnt = cc;
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", {28'd0, q}, 0);
    chk("rst.qb", {28'd0, qb}, 4'hF);
    chk("rst.cnt", {29'd0, chg_cnt}, 0);
    @(negedge clk);
    reset = 1'b1;
    step("jk1", 1, 2'b00, 4'b1100, 4'b1010, 0, 0);
    chk("jk1.const", {28'd0, q}, 4'b1100);
    step("jk2", 1, 2'b00, 4'b1100, 4'b1010, 0, 0);
    chk("jk2.const", {28'd0, q}, 4'b0100);
    chk("jk2.cnt", {29'd0, chg_cnt}, 2);
    step("d_0101", 1, 2'b10, 4'b0101, 4'b0000, 0, 0);
    step("sr_ill", 1, 2'b01, 4'b0011, 4'b0001, 0, 0);
    chk("sr.q", {28'd0, q}, 4'b0111);
    chk("sr.err", {28'd0, err_mask}, 4'b0001);
    step("sr_setwins", 1, 2'b01, 4'b0011, 4'b0001, 1, 0);
    chk("setwins.err", {28'd0, err_mask}, 4'b0001);
    step("sr_clr", 1, 2'b01, 4'b0000, 4'b0000, 1, 0);
    chk("clr.err", {28'd0, err_mask}, 4'b0000);
    step("d", 1, 2'b10, 4'b1001, 4'b0110, 0, 0);
    chk("d.const", {28'd0, q}, 4'b1001);
    step("t1", 1, 2'b11, 4'b1111, 4'b0000, 0, 0);
    chk("t1.const", {28'd0, q}, 4'b0110);
    step("t0", 1, 2'b11, 4'b0000, 4'b1111, 0, 0);
    chk("t0.const", {28'd0, q}, 4'b0110);
    for (int i = 0; i < 5; i++) step("en0", 0, 2'b11, 4'b1111, 4'b0000, 0, 0);
    step("en0_clrcnt", 0, 2'b11, 4'b1111, 4'b0000, 0, 1);
    chk("en0_clrcnt.const", {29'd0, chg_cnt}, 0);
    for (int i = 0; i < 10; i++) step("sat", 1, 2'b11, 4'b0001, 4'b0000, 0, 0);
    chk("sat.cnt", {29'd0, chg_cnt}, 7);
    chk("sat.flag", {31'd0, cnt_sat}, 1);
    step("clr_tog", 1, 2'b11, 4'b0001, 4'b0000, 0, 1);
    chk("clr_tog.cnt", {29'd0, chg_cnt}, 0);
    chk("clr_tog.sat", {31'd0, cnt_sat}, 0);
    step("pre_rst_err", 1, 2'b01, 4'b1111, 4'b1111, 0, 0);
    step("pre_rst_tog", 1, 2'b11, 4'b1010, 4'b0000, 0, 0);
    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    en = 1; mode = 2'b11; a = 4'b1111;
    #2 reset = 1'b0;
    #1;
    chk("arst.q", {28'd0, q}, 0);
    chk("arst.err", {28'd0, err_mask}, 0);
    chk("arst.cnt", {29'd0, chg_cnt}, 0);
    mq = 0; merr = 0; mcnt = 0;
    @(negedge clk);
    reset = 1'b1;
    step("resume", 1, 2'b11, 4'b1111, 4'b0000, 0, 0);
    chk("resume.const", {28'd0, q}, 4'b1111);
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
